// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with abort
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      FUNC3,
   input  logic [XLEN-1:0] OPERAND_A,
   input  logic [XLEN-1:0] OPERAND_B,
   input  logic            KILL,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   typedef enum logic [1:0] {IDLE, PREP, CALC, FINAL} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        func_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [XLEN-1:0]   op_q;
   logic [2*XLEN-1:0] acc;
   logic              neg_q;
   logic [CNT_W-1:0]  cnt;

   logic              is_div;
   logic              a_signed;
   logic              b_signed;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              b_zero;
   logic              ovf;
   logic              special;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_r;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   div_mag;
   logic [XLEN-1:0]   div_res;
   logic [XLEN-1:0]   final_res;

   assign BUSY = (state != IDLE);

   // operand decode, one shift-add / shift-subtract step, and result fix-up
   always_comb begin
      is_div    = func_q[2];
      a_signed  = (func_q == 3'b001) || (func_q == 3'b010) || (func_q == 3'b100) || (func_q == 3'b110);
      b_signed  = (func_q == 3'b001) || (func_q == 3'b100) || (func_q == 3'b110);
      sign_a    = a_signed && a_q[XLEN-1];
      sign_b    = b_signed && b_q[XLEN-1];
      abs_a     = sign_a ? -a_q : a_q;
      abs_b     = sign_b ? -b_q : b_q;
      b_zero    = (b_q == '0);
      ovf       = ((func_q == 3'b100) || (func_q == 3'b110)) &&
                  (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == {XLEN{1'b1}});
      special   = is_div && (b_zero || ovf);

      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? op_q : {XLEN{1'b0}})};
      mul_next  = {mul_sum, acc[XLEN-1:1]};

      // remainder lives in the upper half, dividend/quotient bits in the lower half
      div_r     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_r - {1'b0, op_q};
      div_next  = div_diff[XLEN] ? {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

      prod      = neg_q ? -acc : acc;
      div_mag   = func_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      div_res   = neg_q ? -div_mag : div_mag;
      if (is_div)
         final_res = div_res;
      else if (func_q[1:0] == 2'b00)
         final_res = prod[XLEN-1:0];
      else
         final_res = prod[2*XLEN-1:XLEN];
   end

   // state register
   always_ff @(posedge CLK) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic; KILL overrides every transition
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = PREP;
         PREP:    state_nxt = special ? FINAL : CALC;
         CALC:    if (cnt == '0) state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (KILL)
         state_nxt = IDLE;
   end

   // datapath: operand capture, preparation, iteration and result register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         func_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         acc    <= '0;
         neg_q  <= 1'b0;
         cnt    <= '0;
         DONE   <= 1'b0;
         RESULT <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START && !KILL) begin
                  func_q <= FUNC3;
                  a_q    <= OPERAND_A;
                  b_q    <= OPERAND_B;
               end
            end
            PREP: begin
               if (special) begin
                  // preload acc so FINAL's normal selection yields the fixed answer
                  neg_q <= 1'b0;
                  if (b_zero)
                     acc <= {a_q, {XLEN{1'b1}}};
                  else
                     acc <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
               end else begin
                  op_q  <= is_div ? abs_b : abs_a;
                  acc   <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                  neg_q <= (is_div && func_q[1]) ? sign_a : (sign_a ^ sign_b);
                  cnt   <= CNT_W'(XLEN-1);
               end
            end
            CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt - 1'b1;
            end
            FINAL: begin
               if (!KILL) begin
                  RESULT <= final_res;
                  DONE   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at XLEN 32 and 16
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst32, start32, kill32;
   logic [2:0]  f32;
   logic [31:0] a32, b32;
   logic        busy32, done32;
   logic [31:0] result32;

   logic        rst16, start16, kill16;
   logic [2:0]  f16;
   logic [15:0] a16, b16;
   logic        busy16, done16;
   logic [15:0] result16;

   int checks = 0;
   int errors = 0;
   logic [31:0] q32[$];
   logic [15:0] q16[$];

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut32 (
      .CLK(clk), .RESET(rst32), .START(start32), .FUNC3(f32),
      .OPERAND_A(a32), .OPERAND_B(b32), .KILL(kill32),
      .BUSY(busy32), .DONE(done32), .RESULT(result32)
   );

   muldiv_unit #(.XLEN(16)) dut16 (
      .CLK(clk), .RESET(rst16), .START(start16), .FUNC3(f16),
      .OPERAND_A(a16), .OPERAND_B(b16), .KILL(kill16),
      .BUSY(busy16), .DONE(done16), .RESULT(result16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor for the 32-bit instance
   always @(negedge clk) begin
      logic [31:0] e;
      if (done32) begin
         if (q32.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done32_unexpected: got DONE with %h, expected no DONE", result32);
         end else begin
            e = q32.pop_front();
            check("result32", result32, e);
         end
      end
   end

   // scoreboard monitor for the 16-bit instance
   always @(negedge clk) begin
      logic [15:0] e;
      if (done16) begin
         if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done16_unexpected: got DONE with %h, expected no DONE", result16);
         end else begin
            e = q16.pop_front();
            check("result16", {16'h0, result16}, {16'h0, e});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
      int n;
      int busy_n;
      f32 = f; a32 = a; b32 = b; start32 = 1'b1;
      q32.push_back(exp);
      step();
      start32 = 1'b0;
      a32 = $urandom; b32 = $urandom; f32 = 3'($urandom);
      n = 0;
      busy_n = 0;
      while (!done32 && n < 100) begin
         if (busy32) busy_n++;
         step();
         n++;
      end
      check("latency32", n, lat);
      check("busy_cycles32", busy_n, lat);
      check("busy_low_at_done32", {31'h0, busy32}, 32'h0);
   endtask

   initial begin
      int n;
      int seen;
      rst32 = 1'b1; start32 = 1'b0; kill32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
      rst16 = 1'b1; start16 = 1'b0; kill16 = 1'b0; f16 = '0; a16 = '0; b16 = '0;
      repeat (3) step();
      rst32 = 1'b0;
      rst16 = 1'b0;
      step();
      check("reset_busy32",   {31'h0, busy32}, 32'h0);
      check("reset_done32",   {31'h0, done32}, 32'h0);
      check("reset_result32", result32, 32'h0);
      check("reset_busy16",   {31'h0, busy16}, 32'h0);
      check("reset_done16",   {31'h0, done16}, 32'h0);
      check("reset_result16", {16'h0, result16}, 32'h0);

      run32(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run32(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run32(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      run32(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
      run32(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      run32(3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34);
      run32(3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2);
      run32(3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2);
      run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
      run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      step();

      // abort on the 10th CALC cycle
      f32 = 3'b101; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
      step();
      start32 = 1'b0;
      repeat (10) step();
      kill32 = 1'b1;
      step();
      kill32 = 1'b0;
      check("kill_busy32", {31'h0, busy32}, 32'h0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done32) seen = 1;
         step();
      end
      check("kill_no_done32", seen, 0);
      check("kill_result_kept32", result32, 32'h8000_0000);

      // START together with KILL is refused
      f32 = 3'b101; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1; kill32 = 1'b1;
      step();
      start32 = 1'b0; kill32 = 1'b0;
      check("start_kill_idle32", {31'h0, busy32}, 32'h0);
      step();
      check("start_kill_idle32_b", {31'h0, busy32}, 32'h0);

      run32(3'b101, 32'd100, 32'd7, 32'd14, 34);
      step();

      // XLEN=16: back-to-back launch in the DONE cycle, then an ignored START
      f16 = 3'b000; a16 = 16'd3; b16 = 16'd5; start16 = 1'b1;
      q16.push_back(16'h000F);
      step();
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 100) begin
         step();
         n++;
      end
      check("latency16_first", n, 18);
      f16 = 3'b000; a16 = 16'h00FF; b16 = 16'h0101; start16 = 1'b1;
      q16.push_back(16'hFFFF);
      step();
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 100) begin
         if (n == 3) begin
            start16 = 1'b1; f16 = 3'b100; a16 = 16'd9; b16 = 16'd3;
         end else begin
            start16 = 1'b0;
         end
         step();
         n++;
      end
      start16 = 1'b0;
      check("latency16_b2b", n, 18);
      step();
      check("done16_pulse", {31'h0, done16}, 32'h0);
      check("busy16_after", {31'h0, busy16}, 32'h0);

      // reset in the middle of CALC
      f16 = 3'b000; a16 = 16'd3; b16 = 16'd5; start16 = 1'b1;
      step();
      start16 = 1'b0;
      repeat (6) step();
      rst16 = 1'b1;
      step();
      rst16 = 1'b0;
      check("rst_busy16",   {31'h0, busy16}, 32'h0);
      check("rst_done16",   {31'h0, done16}, 32'h0);
      check("rst_result16", {16'h0, result16}, 32'h0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         if (done16) seen = 1;
         step();
      end
      check("rst_no_done16", seen, 0);

      check("queue32_empty", q32.size(), 0);
      check("queue16_empty", q16.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
